// File: rtl/change_dispenser_if.sv
// change_dispenser_if: pay request, solenoid, sensor, status and refill signals
// between the vending controller side (master) and the dispenser (slave).
interface change_dispenser_if #(
   parameter int AMT_W  = 4,
   parameter int TUBE_W = 6
);
   logic              pay_valid;
   logic [AMT_W-1:0]  pay_amount;
   logic              pay_ready;
   logic              eject_5;
   logic              eject_2;
   logic              eject_1;
   logic              coin_sense;
   logic              busy;
   logic              done;
   logic              short_pay;
   logic [AMT_W-1:0]  paid_out;
   logic              fault;
   logic              fault_clr;
   logic              refill_load;
   logic [1:0]        refill_sel;
   logic [TUBE_W-1:0] refill_cnt;
   modport master (
      output pay_valid, pay_amount, coin_sense, fault_clr, refill_load, refill_sel, refill_cnt,
      input  pay_ready, eject_5, eject_2, eject_1, busy, done, short_pay, paid_out, fault
   );
   modport slave (
      input  pay_valid, pay_amount, coin_sense, fault_clr, refill_load, refill_sel, refill_cnt,
      output pay_ready, eject_5, eject_2, eject_1, busy, done, short_pay, paid_out, fault
   );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: pays change largest-coin-first from 5/2/1 tubes, one solenoid
// pulse per coin, waiting for the chute sensor and faulting on a missing coin.
module change_dispenser #(
   parameter int AMT_W        = 4,
   parameter int TUBE_W       = 6,
   parameter int PULSE_CYCLES = 4,
   parameter int ACK_TIMEOUT  = 255
) (
   input logic clk,
   input logic rst,
   change_dispenser_if.slave io
);
   localparam int PW = $clog2(PULSE_CYCLES) + 1;
   localparam int TW = $clog2(ACK_TIMEOUT) + 1;
   typedef enum logic [2:0] {IDLE, SELECT, PULSE, WAIT_ACK, DONE, FAULT} state_t;
   state_t state_q, state_d;
   logic [AMT_W-1:0] rem_q, rem_d, paid_q, paid_d, val;
   logic short_q, short_d, ack_q, ack_d, found;
   logic [1:0] den_q, den_d, pick;
   logic [2:0][TUBE_W-1:0] tube_q, tube_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [2:0] eject_q, eject_d;
   logic ready_q, busy_q, done_q, fault_q;
   // tube index 2/1/0 holds 5/2/1-unit coins, matching refill_sel encoding
   logic use5, use2, use1;
   assign use5  = rem_q >= AMT_W'(5) && tube_q[2] != '0;
   assign use2  = rem_q >= AMT_W'(2) && tube_q[1] != '0;
   assign use1  = rem_q >= AMT_W'(1) && tube_q[0] != '0;
   assign found = use5 | use2 | use1;
   assign pick  = use5 ? 2'd2 : use2 ? 2'd1 : 2'd0;
   assign val   = den_q == 2'd2 ? AMT_W'(5) : den_q == 2'd1 ? AMT_W'(2) : AMT_W'(1);
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      paid_d  = paid_q;
      short_d = short_q;
      ack_d   = ack_q;
      den_d   = den_q;
      tube_d  = tube_q;
      pcnt_d  = pcnt_q;
      tmr_d   = tmr_q;
      case (state_q)
         IDLE: begin
            if (io.pay_valid) begin
               rem_d   = io.pay_amount;
               paid_d  = '0;
               short_d = 1'b0;
               state_d = SELECT;
            end
            if (io.refill_load && io.refill_sel != 2'b11) tube_d[io.refill_sel] = io.refill_cnt;
         end
         SELECT: begin
            ack_d = 1'b0;
            if (found) begin
               den_d        = pick;
               tube_d[pick] = tube_q[pick] - TUBE_W'(1);
               pcnt_d       = PW'(PULSE_CYCLES - 1);
               state_d      = PULSE;
            end else begin
               short_d = rem_q != '0;
               state_d = DONE;
            end
         end
         PULSE: begin
            if (io.coin_sense) ack_d = 1'b1;
            if (pcnt_q == '0) begin
               tmr_d   = '0;
               state_d = WAIT_ACK;
            end else pcnt_d = pcnt_q - PW'(1);
         end
         WAIT_ACK: begin
            if (ack_q || io.coin_sense) begin
               rem_d   = rem_q - val;
               paid_d  = paid_q + val;
               state_d = SELECT;
            end else if (tmr_q == TW'(ACK_TIMEOUT - 1)) state_d = FAULT;
            else tmr_d = tmr_q + TW'(1);
         end
         DONE: state_d = IDLE;
         FAULT: begin
            rem_d = '0;
            if (io.fault_clr) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      eject_d = state_d == PULSE ? 3'b001 << den_d : 3'b000;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         paid_q  <= '0;
         short_q <= 1'b0;
         ack_q   <= 1'b0;
         den_q   <= '0;
         tube_q  <= '0;
         pcnt_q  <= '0;
         tmr_q   <= '0;
         eject_q <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         paid_q  <= paid_d;
         short_q <= short_d;
         ack_q   <= ack_d;
         den_q   <= den_d;
         tube_q  <= tube_d;
         pcnt_q  <= pcnt_d;
         tmr_q   <= tmr_d;
         eject_q <= eject_d;
         ready_q <= state_d == IDLE;
         busy_q  <= state_d != IDLE;
         done_q  <= state_d == DONE;
         fault_q <= state_d == FAULT;
      end
   assign io.eject_5   = eject_q[2];
   assign io.eject_2   = eject_q[1];
   assign io.eject_1   = eject_q[0];
   assign io.pay_ready = ready_q;
   assign io.busy      = busy_q;
   assign io.done      = done_q;
   assign io.fault     = fault_q;
   assign io.short_pay = short_q;
   assign io.paid_out  = paid_q;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scenario tasks plus randomized payouts checked against a
// largest-first coin model with its own tube inventory.
module tb_change_dispenser;
   localparam int PC = 4;
   localparam int AT = 255;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   change_dispenser_if #(.AMT_W(4), .TUBE_W(6)) bus ();
   change_dispenser #(.AMT_W(4), .TUBE_W(6), .PULSE_CYCLES(PC), .ACK_TIMEOUT(AT)) dut (
      .clk(clk), .rst(rst), .io(bus)
   );
   int total = 0;
   int bad   = 0;
   int mtube [3];
   string obs_seq, exp_seq;
   int obs_wbad, exp_paid;
   bit obs_done, obs_multi, exp_short;

   function automatic void model_pay(input int amt);
      int rem = amt;
      int dv [3] = '{5, 2, 1};
      int ix [3] = '{2, 1, 0};
      bit found;
      exp_seq  = "";
      exp_paid = 0;
      do begin
         found = 0;
         for (int k = 0; k < 3; k++)
            if (!found && dv[k] <= rem && mtube[ix[k]] > 0) begin
               found = 1;
               mtube[ix[k]]--;
               rem -= dv[k];
               exp_paid += dv[k];
               exp_seq = {exp_seq, $sformatf("%0d", dv[k])};
            end
      end while (found);
      exp_short = rem != 0;
   endfunction

   function automatic logic [17:0] exp_tubes();
      return {6'(mtube[2]), 6'(mtube[1]), 6'(mtube[0])};
   endfunction

   task automatic refill(input int sel, input int cnt);
      bus.refill_load = 1'b1;
      bus.refill_sel  = 2'(sel);
      bus.refill_cnt  = 6'(cnt);
      @(negedge clk);
      bus.refill_load = 1'b0;
      if (sel != 3) mtube[sel] = cnt;
   endtask

   // drives one payout and records what the dispenser did; ends on the done cycle
   task automatic run_pay(input int amt, input bit ack_in_pulse, input bit busy_refill);
      logic [2:0] e;
      int w;
      int d;
      obs_seq = ""; obs_wbad = 0; obs_done = 0; obs_multi = 0;
      bus.pay_valid  = 1'b1;
      bus.pay_amount = 4'(amt);
      @(negedge clk);
      bus.pay_valid   = 1'b0;
      bus.refill_load = busy_refill;
      bus.refill_sel  = 2'd0;
      bus.refill_cnt  = 6'h3f;
      for (int c = 0; c < 400 && !obs_done; c++) begin
         e = {bus.eject_5, bus.eject_2, bus.eject_1};
         if (bus.done) obs_done = 1;
         else if (e != 3'b000) begin
            if ($countones(e) > 1) obs_multi = 1;
            d = e[2] ? 5 : e[1] ? 2 : 1;
            w = 0;
            while (e != 3'b000 && w < 50) begin
               if (ack_in_pulse) bus.coin_sense = (w == 0);
               w++;
               @(negedge clk);
               e = {bus.eject_5, bus.eject_2, bus.eject_1};
            end
            bus.coin_sense = 1'b0;
            obs_seq = {obs_seq, $sformatf("%0d", d)};
            if (w != PC) obs_wbad++;
            if (!ack_in_pulse) begin
               repeat (2) @(negedge clk);
               bus.coin_sense = 1'b1;
               @(negedge clk);
               bus.coin_sense = 1'b0;
            end
         end else @(negedge clk);
      end
      bus.refill_load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (bus.pay_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", bus.pay_ready); end
      total++; if ({bus.busy, bus.done, bus.fault, bus.short_pay} !== 4'b0) begin bad++; $display("FAIL rst_flags got %b want 0000", {bus.busy, bus.done, bus.fault, bus.short_pay}); end
      total++; if ({bus.eject_5, bus.eject_2, bus.eject_1} !== 3'b0) begin bad++; $display("FAIL rst_eject got %b want 000", {bus.eject_5, bus.eject_2, bus.eject_1}); end
      total++; if (bus.paid_out !== 4'd0 || dut.tube_q !== 18'd0) begin bad++; $display("FAIL rst_counts paid %0d tubes %h want 0", bus.paid_out, dut.tube_q); end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) mtube[i] = 0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      for (int i = 0; i < 3; i++) refill(i, 3);
      total++; if (dut.tube_q !== exp_tubes()) begin bad++; $display("FAIL refill_idle got %h want %h", dut.tube_q, exp_tubes()); end
      model_pay(8);
      run_pay(8, 0, 0);
      total++; if (obs_done !== 1'b1) begin bad++; $display("FAIL basic_done got %b want 1", obs_done); end
      total++; if (obs_seq != exp_seq) begin bad++; $display("FAIL basic_seq got %s want %s", obs_seq, exp_seq); end
      total++; if (obs_wbad != 0 || obs_multi) begin bad++; $display("FAIL basic_pulse badwidth %0d multi %b want 0 0", obs_wbad, obs_multi); end
      total++; if (bus.paid_out !== 4'(exp_paid) || bus.short_pay !== exp_short) begin bad++; $display("FAIL basic_paid got %0d/%b want %0d/%b", bus.paid_out, bus.short_pay, exp_paid, exp_short); end
      total++; if (dut.tube_q !== exp_tubes()) begin bad++; $display("FAIL basic_tubes got %h want %h", dut.tube_q, exp_tubes()); end
      @(negedge clk);
      total++; if (bus.done !== 1'b0 || bus.pay_ready !== 1'b1) begin bad++; $display("FAIL basic_done_pulse done %b ready %b want 0 1", bus.done, bus.pay_ready); end
   endtask

   task automatic test_zero();
      bus.pay_valid  = 1'b1;
      bus.pay_amount = 4'd0;
      @(negedge clk);
      bus.pay_valid = 1'b0;
      total++; if (bus.done !== 1'b0 || bus.pay_ready !== 1'b0) begin bad++; $display("FAIL zero_early done %b ready %b want 0 0", bus.done, bus.pay_ready); end
      @(negedge clk);
      total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL zero_done got %b want 1", bus.done); end
      total++; if (bus.paid_out !== 4'd0 || {bus.eject_5, bus.eject_2, bus.eject_1} !== 3'b0) begin bad++; $display("FAIL zero_paid paid %0d eject %b want 0 000", bus.paid_out, {bus.eject_5, bus.eject_2, bus.eject_1}); end
      @(negedge clk);
   endtask

   task automatic test_short();
      refill(2, 0); refill(1, 1); refill(0, 1);
      model_pay(7);
      run_pay(7, 0, 0);
      total++; if (obs_done !== 1'b1 || obs_seq != exp_seq) begin bad++; $display("FAIL short_seq done %b got %s want %s", obs_done, obs_seq, exp_seq); end
      total++; if (bus.short_pay !== 1'b1 || bus.paid_out !== 4'd3) begin bad++; $display("FAIL short_flag got %b/%0d want 1/3", bus.short_pay, bus.paid_out); end
      total++; if (dut.tube_q !== exp_tubes()) begin bad++; $display("FAIL short_tubes got %h want %h", dut.tube_q, exp_tubes()); end
      @(negedge clk);
   endtask

   task automatic test_fault();
      int n;
      bit seen;
      refill(0, 2);
      bus.pay_valid  = 1'b1;
      bus.pay_amount = 4'd1;
      @(negedge clk);
      bus.pay_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) if (bus.eject_1) seen = 1; else @(negedge clk);
      total++; if (!seen) begin bad++; $display("FAIL fault_eject got none want eject_1"); end
      n = 0;
      while (!bus.fault && n < 400) begin n++; @(negedge clk); end
      total++; if (n != PC + AT) begin bad++; $display("FAIL fault_time got %0d want %0d", n, PC + AT); end
      mtube[0]--;
      bus.pay_valid  = 1'b1;
      bus.pay_amount = 4'd3;
      repeat (5) @(negedge clk);
      total++; if (bus.pay_ready !== 1'b0 || bus.fault !== 1'b1 || bus.busy !== 1'b1) begin bad++; $display("FAIL fault_hold ready %b fault %b busy %b want 0 1 1", bus.pay_ready, bus.fault, bus.busy); end
      total++; if ({bus.eject_5, bus.eject_2, bus.eject_1} !== 3'b0) begin bad++; $display("FAIL fault_eject_off got %b want 000", {bus.eject_5, bus.eject_2, bus.eject_1}); end
      bus.pay_valid = 1'b0;
      bus.fault_clr = 1'b1;
      @(negedge clk);
      bus.fault_clr = 1'b0;
      total++; if (bus.fault !== 1'b0 || bus.pay_ready !== 1'b1) begin bad++; $display("FAIL fault_clr fault %b ready %b want 0 1", bus.fault, bus.pay_ready); end
      total++; if (dut.tube_q !== exp_tubes()) begin bad++; $display("FAIL fault_tubes got %h want %h", dut.tube_q, exp_tubes()); end
   endtask

   task automatic test_reset_mid();
      bit seen;
      for (int i = 0; i < 3; i++) refill(i, 2);
      bus.pay_valid  = 1'b1;
      bus.pay_amount = 4'd5;
      @(negedge clk);
      bus.pay_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) if (bus.eject_5) seen = 1; else @(negedge clk);
      @(negedge clk);
      total++; if (!seen || bus.eject_5 !== 1'b1) begin bad++; $display("FAIL mid_eject got %b want 1", bus.eject_5); end
      rst = 1'b1;
      #1;
      total++; if ({bus.eject_5, bus.eject_2, bus.eject_1} !== 3'b0 || bus.pay_ready !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL mid_rst eject %b ready %b busy %b want 000 1 0", {bus.eject_5, bus.eject_2, bus.eject_1}, bus.pay_ready, bus.busy); end
      total++; if (bus.paid_out !== 4'd0 || dut.tube_q !== 18'd0) begin bad++; $display("FAIL mid_counts paid %0d tubes %h want 0", bus.paid_out, dut.tube_q); end
      for (int i = 0; i < 3; i++) mtube[i] = 0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ack_in_pulse();
      refill(0, 3); refill(1, 2); refill(2, 1);
      model_pay(9);
      run_pay(9, 1, 1);
      total++; if (obs_done !== 1'b1 || obs_seq != exp_seq) begin bad++; $display("FAIL early_seq done %b got %s want %s", obs_done, obs_seq, exp_seq); end
      total++; if (obs_wbad != 0 || bus.fault !== 1'b0) begin bad++; $display("FAIL early_pulse badwidth %0d fault %b want 0 0", obs_wbad, bus.fault); end
      total++; if (bus.paid_out !== 4'(exp_paid) || bus.short_pay !== exp_short) begin bad++; $display("FAIL early_paid got %0d/%b want %0d/%b", bus.paid_out, bus.short_pay, exp_paid, exp_short); end
      total++; if (dut.tube_q !== exp_tubes()) begin bad++; $display("FAIL busy_refill tubes got %h want %h", dut.tube_q, exp_tubes()); end
      @(negedge clk);
   endtask

   task automatic test_random();
      int amt;
      bit mode;
      for (int it = 0; it < 12; it++) begin
         for (int s = 0; s < 3; s++) refill(s, $urandom_range(0, 3));
         if ($urandom_range(0, 1)) refill(3, 9);
         amt  = $urandom_range(0, 15);
         mode = 1'($urandom_range(0, 1));
         model_pay(amt);
         run_pay(amt, mode, 1'($urandom_range(0, 1)));
         total++; if (obs_done !== 1'b1 || obs_seq != exp_seq) begin bad++; $display("FAIL rnd_seq amt %0d done %b got %s want %s", amt, obs_done, obs_seq, exp_seq); end
         total++; if (obs_wbad != 0 || obs_multi) begin bad++; $display("FAIL rnd_pulse badwidth %0d multi %b want 0 0", obs_wbad, obs_multi); end
         total++; if (bus.paid_out !== 4'(exp_paid) || bus.short_pay !== exp_short) begin bad++; $display("FAIL rnd_paid amt %0d got %0d/%b want %0d/%b", amt, bus.paid_out, bus.short_pay, exp_paid, exp_short); end
         total++; if (dut.tube_q !== exp_tubes()) begin bad++; $display("FAIL rnd_tubes got %h want %h", dut.tube_q, exp_tubes()); end
         @(negedge clk);
      end
   endtask

   initial begin
      bus.pay_valid   = 1'b0;
      bus.pay_amount  = 4'd0;
      bus.coin_sense  = 1'b0;
      bus.fault_clr   = 1'b0;
      bus.refill_load = 1'b0;
      bus.refill_sel  = 2'd0;
      bus.refill_cnt  = 6'd0;
      test_reset();
      test_basic();
      test_zero();
      test_short();
      test_fault();
      test_reset_mid();
      test_ack_in_pulse();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
